// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 6502 bus.
// Decodes work RAM (mirrored), the external device bus and the sprite-DMA
// trigger register. A trigger write starts a page copy to OAM and stalls
// the core through cpu_rdy.
module cpu_bus_responder #(
  parameter int          RAM_AW  = 11,
  parameter logic [15:0] DMA_REG = 16'h4014
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_we,
  output logic        ext_re,
  input  logic [7:0]  ext_rdata,
  output logic [7:0]  oam_wdata,
  output logic        oam_we
);

  typedef enum logic [1:0] {IDLE, ALIGN, DMA_RD, DMA_WR} state_t;

  state_t            state, state_nxt;
  logic [7:0]        page, cnt, rd_q;
  logic [7:0]        ram [0:(1<<RAM_AW)-1];

  logic              idle, sel_ram, trig, dma_ram, core_ext, ram_we, rd_cap;
  logic [15:0]       dma_addr;
  logic [RAM_AW-1:0] rd_idx;
  logic [7:0]        rd_src;

  assign idle     = (state == IDLE);
  assign sel_ram  = (cpu_addr < 16'h2000);
  assign trig     = cpu_we && (cpu_addr == DMA_REG);
  assign dma_addr = {page, cnt};
  assign dma_ram  = (page < 8'h20);

  // Core-side decode is only honoured while idle; strobes are also gated by
  // reset so the external bus is quiet while the block is held in reset.
  assign core_ext = Reset_n && idle && !sel_ram && !trig;
  assign ram_we   = Reset_n && idle && sel_ram && cpu_we;
  assign rd_cap   = (idle && !cpu_we) || (state == DMA_RD);

  assign cpu_rdy   = idle;
  assign cpu_rdata = rd_q;
  assign oam_we    = (state == DMA_WR);
  assign oam_wdata = rd_q;

  // External strobes, address and data; DMA reads of non-RAM pages share the bus.
  always_comb begin
    ext_we    = 1'b0;
    ext_re    = 1'b0;
    ext_addr  = 16'h0000;
    ext_wdata = 8'h00;
    if (state == DMA_RD) begin
      if (Reset_n && !dma_ram) begin
        ext_re   = 1'b1;
        ext_addr = dma_addr;
      end
    end else if (core_ext) begin
      ext_we   = cpu_we;
      ext_re   = !cpu_we;
      ext_addr = cpu_addr;
      if (cpu_we) ext_wdata = cpu_wdata;
    end
  end

  // Read-data source: RAM array (read-before-register) or the external bus.
  always_comb begin
    rd_idx = (state == DMA_RD) ? dma_addr[RAM_AW-1:0] : cpu_addr[RAM_AW-1:0];
    rd_src = ((state == DMA_RD) ? dma_ram : sel_ram) ? ram[rd_idx] : ext_rdata;
  end

  // Next-state logic of the DMA engine.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig) state_nxt = ALIGN;
      ALIGN:   state_nxt = DMA_RD;
      DMA_RD:  state_nxt = DMA_WR;
      DMA_WR:  state_nxt = (cnt == 8'hFF) ? IDLE : DMA_RD;
      default: state_nxt = IDLE;
    endcase
  end

  // Work RAM write port; contents are deliberately not reset.
  always_ff @(posedge Clk) begin
    if (ram_we) ram[cpu_addr[RAM_AW-1:0]] <= cpu_wdata;
  end

  // State, DMA page/count and the load-data register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      page  <= 8'h00;
      cnt   <= 8'h00;
      rd_q  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (rd_cap) rd_q <= rd_src;
      if (idle && trig) begin
        page <= cpu_wdata;
        cnt  <= 8'h00;
      end else if (state == DMA_WR) begin
        cnt  <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: stimulus pushes expected load
// data, external strobes, OAM bytes and stall lengths; a monitor pops and
// compares as the DUT presents them.
module tb_cpu_bus_responder;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_we, ext_re;
  logic [7:0]  ext_rdata;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  cpu_bus_responder dut (
    .Clk(Clk), .Reset_n(Reset_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_re(ext_re),
    .ext_rdata(ext_rdata), .oam_wdata(oam_wdata), .oam_we(oam_we)
  );

  always #5 Clk = ~Clk;

  // External device: $6000 returns $C3, everything else low^high^$5A.
  always_comb ext_rdata = (ext_addr == 16'h6000) ? 8'hC3 : (ext_addr[7:0] ^ ext_addr[15:8] ^ 8'h5A);

  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] wd;} ext_t;

  logic [7:0] exp_rd[$];
  ext_t       exp_ext[$];
  logic [7:0] exp_oam[$];
  int         exp_stall[$];

  int n_vec = 0, n_bad = 0;
  int oam_seen = 0, stall_cnt = 0;
  logic track = 1'b0, rd_done = 1'b0, skip_stall = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A tracked core read completes at this edge; its data is checked next negedge.
  always @(posedge Clk) rd_done <= track && cpu_rdy && !cpu_we && Reset_n;

  // Monitor: loads, external strobes, OAM writes and stall lengths.
  always @(negedge Clk) begin
    if (rd_done) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("cpu_rdata", cpu_rdata, exp_rd.pop_front());
    end
    if (ext_we || ext_re) begin
      if (exp_ext.size() == 0) chk("ext_unexpected", {ext_we, ext_addr}, 0);
      else begin
        ext_t e;
        e = exp_ext.pop_front();
        chk("ext_we", ext_we, e.we);
        chk("ext_re", ext_re, !e.we);
        chk("ext_addr", ext_addr, e.addr);
        if (e.we) chk("ext_wdata", ext_wdata, e.wd);
      end
    end
    if (oam_we) begin
      oam_seen++;
      if (exp_oam.size() == 0) chk("oam_unexpected", oam_wdata, 256);
      else chk("oam_wdata", oam_wdata, exp_oam.pop_front());
    end
    if (Reset_n && !cpu_rdy) stall_cnt++;
    else if (cpu_rdy && stall_cnt > 0) begin
      if (skip_stall) skip_stall = 1'b0;
      else if (exp_stall.size() == 0) chk("stall_unexpected", stall_cnt, 0);
      else chk("stall_len", stall_cnt, exp_stall.pop_front());
      stall_cnt = 0;
    end
  end

  task automatic cyc(input logic we, input logic [15:0] a, input logic [7:0] d, input logic t);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; track = t;
    @(posedge Clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; track = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b1, a, d, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    exp_rd.push_back(e);
    cyc(1'b0, a, 8'h00, 1'b1);
  endtask

  // Called right after the trigger cycle: optionally hold a write, wait for rdy.
  task automatic wait_idle(input logic hold);
    int budget;
    budget = 0;
    if (hold) begin cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hEE; end
    do begin
      @(posedge Clk); #1;
      budget++;
    end while (!cpu_rdy && budget < 700);
    cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    if (budget >= 700) chk("dma_timeout", 0, 1);
  endtask

  initial begin
    int base, budget;
    // Reset state, with an external read presented to prove strobes are gated.
    cpu_addr = 16'h6000;
    #12;
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_rdy", cpu_rdy, 1);
    chk("rst_oam_we", oam_we, 0);
    chk("rst_oam_wdata", oam_wdata, 8'h00);
    chk("rst_ext_strobes", {ext_we, ext_re}, 0);
    chk("rst_ext_addr", ext_addr, 16'h0000);
    chk("rst_ext_wdata", ext_wdata, 8'h00);
    cpu_addr = 16'h0000;
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;

    // RAM mirror and write-then-read forwarding.
    wr(16'h0123, 8'h5A);
    rd(16'h0923, 8'h5A);
    rd(16'h1923, 8'h5A);
    wr(16'h0124, 8'h99);
    rd(16'h0124, 8'h99);

    // External bus accesses; a read of $4014 is an ordinary external read.
    exp_ext.push_back({1'b0, 16'h6000, 8'h00});
    rd(16'h6000, 8'hC3);
    exp_ext.push_back({1'b1, 16'h2001, 8'h11});
    wr(16'h2001, 8'h11);
    exp_ext.push_back({1'b0, 16'h4014, 8'h00});
    rd(16'h4014, 8'h0E);

    // RAM DMA from page $02 with a write held on $0010 throughout.
    for (int i = 0; i < 256; i++) wr(16'h0200 + 16'(i), 8'(i));
    wr(16'h0010, 8'h33);
    wr(16'h0000, 8'h77);
    for (int i = 0; i < 256; i++) exp_oam.push_back(8'(i));
    exp_stall.push_back(513);
    wr(16'h4014, 8'h02);
    wait_idle(1'b1);
    chk("rdata_after_dma", cpu_rdata, 8'hFF);
    rd(16'h0010, 8'h33);

    // External DMA from page $80.
    for (int i = 0; i < 256; i++) begin
      exp_ext.push_back({1'b0, 16'h8000 + 16'(i), 8'h00});
      exp_oam.push_back(8'(i) ^ 8'hDA);
    end
    exp_stall.push_back(513);
    wr(16'h4014, 8'h80);
    wait_idle(1'b0);

    // Reset after 100 OAM writes of a RAM DMA.
    for (int i = 0; i < 256; i++) exp_oam.push_back(8'(i));
    base = oam_seen;
    wr(16'h4014, 8'h02);
    budget = 0;
    while (oam_seen < base + 100 && budget < 400) begin
      @(negedge Clk); #2;
      budget++;
    end
    if (budget >= 400) chk("oam_count_timeout", 0, 1);
    Reset_n = 1'b0;
    skip_stall = 1'b1;
    #1;
    chk("mid_rst_rdy", cpu_rdy, 1);
    chk("mid_rst_oam_we", oam_we, 0);
    chk("oam_before_rst", oam_seen - base, 100);
    exp_oam.delete();
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;
    rd(16'h0000, 8'h77);
    repeat (4) @(posedge Clk);
    #1;
    chk("oam_after_rst", oam_seen - base, 100);

    // Everything expected was seen.
    chk("rd_left", exp_rd.size(), 0);
    chk("ext_left", exp_ext.size(), 0);
    chk("oam_left", exp_oam.size(), 0);
    chk("stall_left", exp_stall.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
